risc_int_ctrl: RTL
==================

# risc_int_ctrl

Prioritised interrupt controller placed between external interrupt sources and the `INT` input of the `risc` core. It edge-detects up to `N_SRC` request lines, latches them as pending, applies a software-writable mask, and runs an irq/ack/iret handshake with the core. For each accepted interrupt it supplies a handler vector and the in-service source id. The core's single `INT` line becomes a serialised, prioritised interrupt stream.

## Interface
- `N_SRC`, 4: number of interrupt sources (2..8).
- `VEC_W`, 32: vector width, matching the core PC width.
- `BASE_VEC`, 32'h0000_0100: vector of source 0; vector of source i = `BASE_VEC + 4*i`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low (0 = reset, sampled on the `clk` rising edge).
- `src`  in  N_SRC  raw request lines; each rising edge is one request.
- `mask_we`  in  1  load the mask register.
- `mask_wdata`  in  N_SRC  new mask; bit = 1 means the source is blocked.
- `ack`  in  1  core accepts the presented interrupt.
- `iret`  in  1  core finished its handler (one-cycle pulse).
- `irq`  out  1  interrupt request to the core `INT` input.
- `vec`  out  VEC_W  handler address, valid while `irq` = 1.
- `isr_id`  out  3  id of the presented or in-service source.
- `busy`  out  1  a handler is in service.
- `pend`  out  N_SRC  pending register, for the debug display.

## Operation
- Edge detect: `src_q <= src` every cycle.
  - `pend[i]` sets on any edge where `src[i] & ~src_q[i]`.
  - Pending bits are recorded regardless of mask state.
- Eligible set = `pend & ~mask`. Priority is fixed; lowest index wins.
- State machine:
  - IDLE: when the eligible set is non-empty, latch `id` and `vec`, set `irq` = 1, go to PEND.
  - PEND: `irq`, `vec` and `isr_id` are held stable until `ack` = 1. On `ack`: clear `pend[id]`, set `irq` = 0 and `busy` = 1, go to SERV.
  - SERV: on `iret`, set `busy` = 0 and go to IDLE. With no `iret`, remain in SERV; new edges are still recorded as pending.
- Boundary rules:
  - `ack` outside PEND is ignored.
  - `iret` outside SERV (or SERV2) is ignored.
  - A new edge on `src[id]` in the same cycle as its `ack` clear: set wins, and the bit stays pending.
  - A mask write while in PEND does not withdraw the request already presented.
  - A mask write takes effect for selections made on the following cycle.
  - A held-high `src` generates exactly one request.
  - Reset (any state, any cycle):
    - `pend`, `mask`, `src_q`, `irq`, `vec`, `isr_id` and `busy` all go to 0.
    - State goes to IDLE.
    - `src_q` = 0 means a line held high through reset registers one request after reset is released.

## Timing
- `src[i]` first sampled high at edge k:
  - `pend[i]` = 1 after edge k.
  - `irq` = 1 after edge k+1, assuming IDLE, unmasked, and highest priority.
- `ack` sampled at edge m: `irq` = 0 and `busy` = 1 after edge m.
- `iret` sampled at edge n: IDLE after edge n.
  - The next pending interrupt raises `irq` after edge n+1.
  - Minimum gap between handlers is 1 idle cycle.
- `vec` and `isr_id` are registered, never combinational from `src`.

## Configuration
- `RISC_INT_NEST_EN` defined: one nesting level is supported.
  - In SERV, if an eligible source has index < the in-service id, the controller saves the id and presents the new request (PEND2). On `ack` it goes to SERV2.
  - `iret` in SERV2 restores the saved id and returns to SERV with `busy` still 1.
  - SERV2 never preempts.
- Not defined: PEND2 and SERV2 do not exist; SERV is never preempted.

## Structure
- Package `risc_int_pkg`:
  - state enum: IDLE, PEND, SERV, PEND2, SERV2;
  - default `N_SRC` and `BASE_VEC`;
  - vector stride constant (4).
- Sub-module `int_prio_enc`: combinational N_SRC-input lowest-index-first encoder producing `valid` and `id`. It is instantiated once in the controller.

## Test plan
- Reset then pulse `src[2]`:
  - `irq` = 1 two edges later with `vec` = 0x108 and `isr_id` = 2;
  - `ack` gives `busy` = 1 and `pend` = 0;
  - `iret` returns `busy` = 0.
- `src[1]` and `src[3]` rise together:
  - source 1 is served first (`vec` = 0x104);
  - after `iret`, `irq` reasserts one idle cycle later with `vec` = 0x10C.
- Mask = 4'b0100, pulse `src[2]`:
  - `pend[2]` = 1 and `irq` stays 0;
  - write mask 0, then `irq` rises 1 cycle later.
- Hold `src[0]` high for 20 cycles: exactly one interrupt is delivered. Assert reset during PEND: all outputs are 0 on the next edge.
- New `src[2]` edge in the same cycle as `ack` of source 2: after `iret`, a second source-2 interrupt is presented.
- `RISC_INT_NEST_EN`:
  - serving source 3, pulse `src[0]` → `irq` with `vec` = 0x100; `ack`, then `iret` gives SERV with `isr_id` = 3.
  - Without the macro, source 0 waits until source 3 `iret`.

Source files
------------

// File: rtl/risc_int_pkg.sv
// Shared types and constants for the risc_int_ctrl interrupt controller.
package risc_int_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        SERV  = 3'd2,
        PEND2 = 3'd3,
        SERV2 = 3'd4
    } int_state_e;

    localparam int          DEF_N_SRC    = 4;
    localparam logic [31:0] DEF_BASE_VEC = 32'h0000_0100;
    localparam int          VEC_STRIDE   = 4;

    // Byte offset of a source's handler from the base vector.
    function automatic logic [31:0] vec_offset(input logic [2:0] id);
        return 32'(VEC_STRIDE) * {29'b0, id};
    endfunction

endpackage

// File: rtl/risc_int_ctrl_prio_enc.sv
// int_prio_enc: combinational lowest-index-first priority encoder.
module int_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan downward so the lowest set index is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = 3'(i);
        end
    end

endmodule

// File: rtl/risc_int_ctrl.sv
// risc_int_ctrl: edge-detecting, masked, fixed-priority interrupt controller.
// Define RISC_INT_NEST_EN to allow one level of preemption of an in-service handler.
module risc_int_ctrl
    import risc_int_pkg::*;
#(
    parameter int               N_SRC    = DEF_N_SRC,
    parameter int               VEC_W    = 32,
    parameter logic [VEC_W-1:0] BASE_VEC = VEC_W'(DEF_BASE_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             ack,
    input  logic             iret,
    output logic             irq,
    output logic [VEC_W-1:0] vec,
    output logic [2:0]       isr_id,
    output logic             busy,
    output logic [N_SRC-1:0] pend,
    output logic [2:0]       dbg_state
);

    // Handshake: irq/vec/isr_id are held until the core samples ack=1 while a
    // request is presented; the core then pulses iret once when its handler is
    // done. ack without a presented request and iret without a handler in
    // service are ignored.

    int_state_e       state, state_n;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] mask;
    logic [2:0]       saved_id;

    logic [N_SRC-1:0] rises;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic             enc_valid;
    logic [2:0]       enc_id;

    logic present;
    logic accept;
    logic finish;
    logic restore;

    assign rises     = src & ~src_q;
    assign eligible  = pend & ~mask;
    assign clr       = accept ? (N_SRC'(1) << isr_id) : '0;
    assign dbg_state = state;

    int_prio_enc #(.N(N_SRC)) u_enc (
        .req   (eligible),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        present = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        restore = 1'b0;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    present = 1'b1;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (ack) begin
                    accept  = 1'b1;
                    state_n = SERV;
                end
            end
            SERV: begin
                if (iret) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
`ifdef RISC_INT_NEST_EN
                else if (enc_valid && (enc_id < isr_id)) begin
                    present = 1'b1;
                    state_n = PEND2;
                end
`endif
            end
            PEND2: begin
                if (ack) begin
                    accept  = 1'b1;
                    state_n = SERV2;
                end
            end
            SERV2: begin
                if (iret) begin
                    restore = 1'b1;
                    state_n = SERV;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q    <= '0;
            mask     <= '0;
            pend     <= '0;
            irq      <= 1'b0;
            vec      <= '0;
            isr_id   <= '0;
            busy     <= 1'b0;
            saved_id <= '0;
        end else begin
            src_q <= src;
            if (mask_we) mask <= mask_wdata;
            // A new edge on the source being acknowledged keeps it pending.
            pend <= (pend & ~clr) | rises;
            if (present) begin
                irq    <= 1'b1;
                vec    <= BASE_VEC + VEC_W'(vec_offset(enc_id));
                isr_id <= enc_id;
                if (state == SERV) saved_id <= isr_id;
            end
            if (accept) begin
                irq  <= 1'b0;
                busy <= 1'b1;
            end
            if (finish)  busy   <= 1'b0;
            if (restore) isr_id <= saved_id;
        end
    end

endmodule
